// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared constants and types for the scratch RAM controller.
// Holds the opcode select nibbles, operation codes, response destination
// encodings and the controller FSM state type.
package ram_ctrl_pkg;

  // Select nibble, opcode[15:12]
  localparam logic [3:0] RAM_OP = 4'h4;
  localparam logic [3:0] ROM_OP = 4'h3;
  localparam logic [3:0] REG_OP = 4'h9;
  localparam logic [3:0] PC_OP  = 4'h7;

  // Operation code, opcode[11:8]
  localparam logic [3:0] RAM_WRITE = 4'h1;
  localparam logic [3:0] RAM_READ  = 4'h2;
  localparam logic [3:0] RAM_CLEAR = 4'h3;

  // rsp_dest encodings
  localparam logic [1:0] DEST_OUT = 2'd0;
  localparam logic [1:0] DEST_REG = 2'd1;
  localparam logic [1:0] DEST_PC  = 2'd2;

  typedef enum logic {
    StSweep = 1'b0,
    StIdle  = 1'b1
  } state_e;

  // Selects whose WRITE operation stores into the array
  function automatic logic is_write_sel(input logic [3:0] sel);
    return (sel == RAM_OP) || (sel == ROM_OP) || (sel == REG_OP);
  endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: request/response bus of the scratch RAM controller.
//   opcode, operand, write_data, req_valid : request (master -> slave)
//   req_ready                              : request accepted (slave -> master)
//   rsp_valid, rsp_data, rsp_dest          : held read response (slave -> master)
//   rsp_ready                              : response consumed (master -> slave)
//   busy                                   : zero-fill sweep in progress
interface ram_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  req_valid;
  logic                  req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_dest;
  logic                  busy;

  modport master (
    output opcode, operand, write_data, req_valid, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_dest, busy
  );

  modport slave (
    input  opcode, operand, write_data, req_valid, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_dest, busy
  );

endinterface

// File: rtl/ram_ctrl_mem.sv
// ram_ctrl_mem: single-port synchronous DEPTH x DATA_WIDTH array.
//   clk_i, rst_ni : clock, async active-low reset (read register only)
//   we_i          : write wdata_i to addr_i on the rising edge
//   re_i          : load rdata_o from addr_i on the rising edge
//   rdata_o       : registered read data, held while re_i is low
module ram_ctrl_mem #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  // Contents are not reset; the controller's sweep zero-fills them
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Held read register doubles as the response data register
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: scratch RAM controller. Decodes the shared opcode bus into
// writes, tagged reads and bulk clears, and zero-fills the array after reset
// (CLEAR_ON_RESET) and on a RAM_OP/CLEAR request.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : request/response bus, see ram_ctrl_if
// DATA_WIDTH must be >= 16 and ADDR_WIDTH <= 8.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  ram_ctrl_if.slave  bus
);

  localparam state_e ResetState = CLEAR_ON_RESET ? StSweep : StIdle;

  state_e                state_d, state_q;
  logic [ADDR_WIDTH-1:0] cnt_d, cnt_q;
  logic                  rsp_valid_d, rsp_valid_q;
  logic [1:0]            rsp_dest_d, rsp_dest_q;

  logic [3:0]            sel, op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready, accept;
  logic                  wr_req, rd_req, clr_req;
  logic [1:0]            rd_dest;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign sel      = bus.opcode[15:12];
  assign op       = bus.opcode[11:8];
  // ROM-path ops carry their address in the opcode low byte
  assign req_addr = (sel == ROM_OP) ? ADDR_WIDTH'(bus.opcode) : ADDR_WIDTH'(bus.operand);

  // Held low in reset so nothing is taken before state is valid
  assign req_ready = reset && (state_q == StIdle) && (!rsp_valid_q || bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    clr_req = 1'b0;
    rd_dest = DEST_OUT;
    if (accept) begin
      if (sel == PC_OP) begin
        rd_req  = 1'b1;
        rd_dest = DEST_PC;
      end else if (op == RAM_WRITE && is_write_sel(sel)) begin
        wr_req = 1'b1;
      end else if (op == RAM_READ && sel == RAM_OP) begin
        rd_req = 1'b1;
      end else if (op == RAM_READ && sel == REG_OP) begin
        rd_req  = 1'b1;
        rd_dest = DEST_REG;
      end else if (op == RAM_CLEAR && sel == RAM_OP) begin
        clr_req = 1'b1;
      end
      // Anything else is accepted and dropped
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ResetState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StSweep: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);  // wraps to 0 after the last word
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (clr_req) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      default: state_d = ResetState;
    endcase
  end

  // FSM: outputs and array port mux
  always_comb begin
    bus.busy  = 1'b0;
    mem_we    = wr_req;
    mem_addr  = req_addr;
    mem_wdata = bus.write_data;
    unique case (state_q)
      StSweep: begin
        bus.busy  = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
      end
      StIdle:  ;
      default: ;
    endcase
  end

  // Response register: a new read reloads it even while the old one is consumed
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_dest_d  = rsp_dest_q;
    if (rd_req) begin
      rsp_valid_d = 1'b1;
      rsp_dest_d  = rd_dest;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_dest_q  <= DEST_OUT;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_dest_q  <= rsp_dest_d;
    end
  end

  ram_ctrl_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (mem_we),
    .re_i    (rd_req),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (rsp_data)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_dest  = rsp_dest_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed and randomized bench for ram_ctrl with a
// transaction-level reference model (word array, pending response, sweep
// countdown) updated once per clock.
module tb_ram_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  ram_ctrl_if #(.DATA_WIDTH(16)) bus ();

  ram_ctrl #(
    .DATA_WIDTH     (16),
    .ADDR_WIDTH     (8),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model
  logic [15:0] mem_m [256];
  int          sweep_left = 0;
  bit          pend = 1'b0;
  logic [15:0] rsp_data_m = '0;
  logic [1:0]  rsp_dest_m = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
  endtask

  // Called just after a falling edge; drives one cycle, checks, advances
  // the model across the rising edge and returns on the next falling edge.
  task automatic cycle(input bit v, input logic [15:0] opc, input logic [15:0] opr,
                       input logic [15:0] wd, input bit rr);
    bit         exp_ready;
    logic [3:0] sel, op;
    logic [7:0] a;
    bus.req_valid  = v;
    bus.opcode     = opc;
    bus.operand    = opr;
    bus.write_data = wd;
    bus.rsp_ready  = rr;
    #2;
    exp_ready = (sweep_left == 0) && (!pend || rr);
    check("req_ready", bus.req_ready, exp_ready);
    check("busy", bus.busy, sweep_left != 0);
    check("rsp_valid", bus.rsp_valid, pend);
    if (pend) begin
      check("rsp_data", bus.rsp_data, rsp_data_m);
      check("rsp_dest", bus.rsp_dest, rsp_dest_m);
    end
    @(posedge clk);
    if (sweep_left > 0) sweep_left--;
    if (pend && rr) pend = 1'b0;
    if (v && exp_ready) begin
      sel = opc[15:12];
      op  = opc[11:8];
      a   = (sel == 4'h3) ? opc[7:0] : opr[7:0];
      if (sel == 4'h7) begin
        pend = 1'b1; rsp_data_m = mem_m[a]; rsp_dest_m = 2'd2;
      end else if (op == 4'h1 && (sel == 4'h4 || sel == 4'h3 || sel == 4'h9)) begin
        mem_m[a] = wd;
      end else if (op == 4'h2 && sel == 4'h4) begin
        pend = 1'b1; rsp_data_m = mem_m[a]; rsp_dest_m = 2'd0;
      end else if (op == 4'h2 && sel == 4'h9) begin
        pend = 1'b1; rsp_data_m = mem_m[a]; rsp_dest_m = 2'd1;
      end else if (op == 4'h3 && sel == 4'h4) begin
        sweep_left = 256;
        model_clear();
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
  endtask

  // Asynchronous assert between edges, held across two rising edges
  task automatic do_reset();
    #3 reset = 1'b0;
    #1;
    pend = 1'b0; sweep_left = 256; rsp_data_m = '0; rsp_dest_m = '0;
    model_clear();
    check("rst_busy", bus.busy, 1'b1);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 16'h0);
    check("rst_rsp_dest", bus.rsp_dest, 2'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_rsp_valid", bus.rsp_valid, 1'b0);
    reset = 1'b1;
  endtask

  // Offers a write to 0x7F every sweep cycle; it must never be taken
  task automatic count_busy(input string tag);
    int n = 0;
    while (bus.busy && n < 600) begin
      cycle(1'b1, 16'h4100, 16'h007F, 16'hDEAD, 1'b1);
      n++;
    end
    check(tag, n, 256);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.opcode     = '0;
    bus.operand    = '0;
    bus.write_data = '0;
    bus.rsp_ready  = 1'b1;
    @(negedge clk);

    do_reset();
    count_busy("init_sweep_len");

    // PC read of 0x7F after the sweep
    cycle(1'b1, 16'h7200, 16'h007F, 16'h0, 1'b1);
    check("pc_rd_valid", bus.rsp_valid, 1'b1);
    check("pc_rd_data", bus.rsp_data, 16'h0000);
    check("pc_rd_dest", bus.rsp_dest, 2'd2);

    // Write then read in the next cycle
    cycle(1'b1, 16'h9100, 16'h0012, 16'hBEEF, 1'b1);
    cycle(1'b1, 16'h9200, 16'h0012, 16'h0, 1'b1);
    check("reg_rd_valid", bus.rsp_valid, 1'b1);
    check("reg_rd_data", bus.rsp_data, 16'hBEEF);
    check("reg_rd_dest", bus.rsp_dest, 2'd1);

    // ROM-path write ignores operand
    cycle(1'b1, 16'h3145, 16'h0099, 16'h1234, 1'b1);
    cycle(1'b1, 16'h4200, 16'h0045, 16'h0, 1'b1);
    check("rom_wr_data", bus.rsp_data, 16'h1234);
    check("rom_wr_dest", bus.rsp_dest, 2'd0);
    cycle(1'b1, 16'h4200, 16'h0099, 16'h0, 1'b1);
    check("rom_wr_operand_ignored", bus.rsp_data, 16'h0000);
    idle(1);

    // Back-pressure, then back-to-back response
    cycle(1'b1, 16'h4200, 16'h0045, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h9200, 16'h0012, 16'h0, 1'b0);
    check("bp_data_stable", bus.rsp_data, 16'h1234);
    cycle(1'b1, 16'h9200, 16'h0012, 16'h0, 1'b1);
    check("b2b_valid", bus.rsp_valid, 1'b1);
    check("b2b_data", bus.rsp_data, 16'hBEEF);
    check("b2b_dest", bus.rsp_dest, 2'd1);
    idle(1);

    // Unknown opcode: taken, no response, memory untouched
    cycle(1'b1, 16'h5100, 16'h0012, 16'hDEAD, 1'b1);
    check("unk_no_rsp", bus.rsp_valid, 1'b0);
    cycle(1'b1, 16'h9200, 16'h0012, 16'h0, 1'b1);
    check("unk_mem_kept", bus.rsp_data, 16'hBEEF);
    idle(1);

    // Fill two addresses, clear, read both back as zero
    cycle(1'b1, 16'h4100, 16'h0010, 16'hAAAA, 1'b1);
    cycle(1'b1, 16'h31FF, 16'h0000, 16'h5555, 1'b1);
    cycle(1'b1, 16'h4200, 16'h00FF, 16'h0, 1'b1);
    check("fill_ff", bus.rsp_data, 16'h5555);
    cycle(1'b1, 16'h4300, 16'h0000, 16'h0, 1'b1);
    count_busy("clear_sweep_len");
    cycle(1'b1, 16'h4200, 16'h0010, 16'h0, 1'b1);
    check("clr_10", bus.rsp_data, 16'h0000);
    cycle(1'b1, 16'h4200, 16'h00FF, 16'h0, 1'b1);
    check("clr_ff", bus.rsp_data, 16'h0000);
    idle(1);

    // Reset with a response held: it is dropped
    cycle(1'b1, 16'h4200, 16'h0010, 16'h0, 1'b0);
    do_reset();
    count_busy("rst_rsp_sweep_len");

    // Reset 100 cycles into a CLEAR sweep: full restart
    cycle(1'b1, 16'h4100, 16'h0020, 16'h7777, 1'b1);
    cycle(1'b1, 16'h4300, 16'h0000, 16'h0, 1'b1);
    idle(100);
    do_reset();
    count_busy("restart_sweep_len");
    cycle(1'b1, 16'h4200, 16'h0020, 16'h0, 1'b1);
    check("restart_20", bus.rsp_data, 16'h0000);
    idle(1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [3:0] sel, op;
      logic [7:0] a_opc, a_opr;
      int         r;
      r = int'($urandom_range(0, 5));
      case (r)
        0: sel = 4'h3;
        1: sel = 4'h4;
        2: sel = 4'h7;
        3: sel = 4'h9;
        4: sel = 4'h4;
        default: sel = 4'($urandom());
      endcase
      r = int'($urandom_range(0, 63));
      if (r == 0) op = 4'h3;
      else if (r < 28) op = 4'h1;
      else if (r < 56) op = 4'h2;
      else op = 4'($urandom());
      a_opc = 8'($urandom_range(0, 15));
      a_opr = 8'($urandom_range(0, 15));
      cycle($urandom_range(0, 9) < 7, {sel, op, a_opc}, {8'($urandom()), a_opr},
            16'($urandom()), $urandom_range(0, 9) < 6);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
